uart_rx_frame_ctrl: RTL and testbench

UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

---
 rtl/uart_rx_frame_ctrl_pkg.sv | 18 +
 rtl/uart_rx_frame_ctrl_buf.sv | 26 ++
 rtl/uart_rx_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART frame receiver: FSM state encoding,
// error codes reported on err_code, and the default start-of-frame byte.
package uart_defs;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_LEN = 3'd1;
  localparam logic [2:0] ST_GET_PAY = 3'd2;
  localparam logic [2:0] ST_GET_CHK = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] DEFAULT_SOF = 8'hA5;

endpackage

// File: rtl/uart_rx_frame_ctrl_buf.sv
// Payload storage for one frame: a single synchronous write port fed by the
// receive path and a combinational read port feeding the drain path.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Store a payload byte; contents are overwritten by the next frame, so no reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame controller sitting behind a UART byte receiver. Collects
// SOF, LEN, payload, CHK frames, validates length and XOR checksum, guards
// against inter-byte silence, and replays a good payload on a valid/ready port.
module uart_rx_frame_ctrl
  import uart_defs::*;
#(
  parameter int unsigned MAX_LEN       = 16,
  parameter logic [7:0]  SOF           = DEFAULT_SOF,
  parameter int unsigned TIMEOUT_TICKS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_busy,
  input  logic       tick_8x,
  output logic       rx_en,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic       pl_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam int unsigned   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned   TW        = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    wr_ptr_q, wr_ptr_d;
  logic [7:0]    rd_ptr_q, rd_ptr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          frame_ok_q, frame_ok_d;
  logic          frame_err_q, frame_err_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          in_get;
  logic          tmo_count;
  logic          tmo_hit;
  logic          buf_we;
  logic [7:0]    buf_rdata;

  assign in_get    = (state_q == ST_GET_LEN) || (state_q == ST_GET_PAY) ||
                     (state_q == ST_GET_CHK);
  assign tmo_count = in_get && tick_8x && !rx_busy;
  assign tmo_hit   = tmo_count && (tmo_q == TMO_LAST);

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (rx_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (buf_rdata)
  );

  // Next-state logic: frame parsing, checksum, timeout and drain handshake
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    chk_d       = chk_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    buf_we      = 1'b0;

    // The silence counter only runs while a frame is half received; a new byte
    // always restarts it, which also lets rx_done beat a coinciding final tick.
    if (!in_get || rx_done) begin
      tmo_d = '0;
    end else if (tmo_count) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable && rx_done && (rx_data == SOF)) begin
          state_d = ST_GET_LEN;
        end
      end

      ST_GET_LEN, ST_GET_PAY, ST_GET_CHK: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (rx_done) begin
          if (state_q == ST_GET_LEN) begin
            if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
              state_d     = ST_IDLE;
              frame_err_d = 1'b1;
              err_code_d  = ERR_LEN;
            end else begin
              len_d    = rx_data;
              chk_d    = rx_data;
              wr_ptr_d = 8'd0;
              rd_ptr_d = 8'd0;
              state_d  = ST_GET_PAY;
            end
          end else if (state_q == ST_GET_PAY) begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 8'd1;
            chk_d    = chk_q ^ rx_data;
            if (wr_ptr_q == (len_q - 8'd1)) begin
              state_d = ST_GET_CHK;
            end
          end else begin
            if (rx_data == chk_q) begin
              state_d    = ST_DRAIN;
              frame_ok_d = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              frame_err_d = 1'b1;
              err_code_d  = ERR_CHK;
            end
          end
        end else if (tmo_hit) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
        end
      end

      ST_DRAIN: begin
        if (pl_ready) begin
          if (rd_ptr_q == (len_q - 8'd1)) begin
            rd_ptr_d = 8'd0;
            state_d  = ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Register update with synchronous reset that drops any buffered frame silently
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      len_q       <= 8'd0;
      chk_q       <= 8'd0;
      wr_ptr_q    <= 8'd0;
      rd_ptr_q    <= 8'd0;
      tmo_q       <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tmo_q       <= tmo_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign rx_en     = enable && (state_q != ST_DRAIN);
  assign pl_valid  = (state_q == ST_DRAIN);
  assign pl_data   = pl_valid ? buf_rdata : 8'h00;
  assign pl_last   = pl_valid && (rd_ptr_q == (len_q - 8'd1));
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good frames, length, checksum and
// timeout errors, enable abort, stalled drain and reset in mid-frame.
module tb_uart_rx_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       rx_busy;
  logic       tick_8x;
  logic       rx_en;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       pl_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;

  int checks   = 0;
  int errors   = 0;
  int ok_cnt   = 0;
  int err_cnt  = 0;
  int hs_cnt   = 0;
  int both_cnt = 0;
  int ok0, err0, hs0;
  logic [7:0] hs_data [$];

  // Free-running 100 MHz clock
  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .MAX_LEN       (16),
    .SOF           (8'hA5),
    .TIMEOUT_TICKS (1024)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .rx_busy   (rx_busy),
    .tick_8x   (tick_8x),
    .rx_en     (rx_en),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_last   (pl_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code)
  );

  // Pulse and handshake monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_ok) ok_cnt++;
    if (frame_err) err_cnt++;
    if (frame_ok && frame_err) both_cnt++;
    if (pl_valid && pl_ready) begin
      hs_cnt++;
      hs_data.push_back(pl_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    rx_busy  = 1'b0;
    tick_8x  = 1'b0;
    pl_ready = 1'b0;

    // Reset state
    repeat (3) step();
    checkOutput("rst_pl_valid", 32'(pl_valid), 32'd0);
    checkOutput("rst_pl_last", 32'(pl_last), 32'd0);
    checkOutput("rst_pl_data", 32'(pl_data), 32'd0);
    checkOutput("rst_frame_ok", 32'(frame_ok), 32'd0);
    checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    checkOutput("rst_err_code", 32'(err_code), 32'd0);
    checkOutput("rst_rx_en", 32'(rx_en), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    step();
    checkOutput("idle_rx_en", 32'(rx_en), 32'd1);

    // Good 3-byte frame, CHK = 03^11^22^33 = 03
    $display("[TB] good 3-byte frame");
    pl_ready = 1'b1;
    hs_data.delete();
    hs0 = hs_cnt;
    applyStimulus(8'hA5); applyStimulus(8'h03);
    applyStimulus(8'h11); applyStimulus(8'h22); applyStimulus(8'h33);
    applyStimulus(8'h03);
    checkOutput("g3_frame_ok", 32'(frame_ok), 32'd1);
    checkOutput("g3_valid", 32'(pl_valid), 32'd1);
    checkOutput("g3_data0", 32'(pl_data), 32'h11);
    checkOutput("g3_last0", 32'(pl_last), 32'd0);
    checkOutput("g3_rx_en_drain", 32'(rx_en), 32'd0);
    step();
    checkOutput("g3_ok_pulse", 32'(frame_ok), 32'd0);
    checkOutput("g3_data1", 32'(pl_data), 32'h22);
    step();
    checkOutput("g3_data2", 32'(pl_data), 32'h33);
    checkOutput("g3_last2", 32'(pl_last), 32'd1);
    checkOutput("g3_rx_en_drain2", 32'(rx_en), 32'd0);
    step();
    checkOutput("g3_valid_end", 32'(pl_valid), 32'd0);
    checkOutput("g3_rx_en_end", 32'(rx_en), 32'd1);
    checkOutput("g3_hs_count", 32'(hs_cnt - hs0), 32'd3);
    checkOutput("g3_hs_b2", 32'(hs_data[2]), 32'h33);

    // Checksum error (02^10^20 = 32, not 00), then a valid frame
    $display("[TB] checksum error then recovery");
    applyStimulus(8'hA5); applyStimulus(8'h02);
    applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h00);
    checkOutput("chk_frame_err", 32'(frame_err), 32'd1);
    checkOutput("chk_err_code", 32'(err_code), 32'd2);
    checkOutput("chk_no_valid", 32'(pl_valid), 32'd0);
    step();
    checkOutput("chk_err_pulse", 32'(frame_err), 32'd0);
    checkOutput("chk_code_held", 32'(err_code), 32'd2);
    applyStimulus(8'hA5); applyStimulus(8'h02);
    applyStimulus(8'h10); applyStimulus(8'h20); applyStimulus(8'h32);
    checkOutput("rec_frame_ok", 32'(frame_ok), 32'd1);
    checkOutput("rec_data0", 32'(pl_data), 32'h10);
    step();
    checkOutput("rec_data1", 32'(pl_data), 32'h20);
    checkOutput("rec_last", 32'(pl_last), 32'd1);
    step();
    checkOutput("rec_valid_end", 32'(pl_valid), 32'd0);

    // Bad LEN: zero and MAX_LEN+1
    $display("[TB] bad length");
    applyStimulus(8'hA5); applyStimulus(8'h00);
    checkOutput("len0_err", 32'(frame_err), 32'd1);
    checkOutput("len0_code", 32'(err_code), 32'd1);
    step();
    applyStimulus(8'hA5); applyStimulus(8'h11);
    checkOutput("len17_err", 32'(frame_err), 32'd1);
    checkOutput("len17_code", 32'(err_code), 32'd1);
    step();

    // Maximum length frame: payload 01..10, CHK = 10 ^ (01^..^10) = 00
    $display("[TB] full 16-byte frame");
    hs_data.delete();
    hs0 = hs_cnt;
    applyStimulus(8'hA5); applyStimulus(8'h10);
    for (int i = 1; i <= 16; i++) applyStimulus(8'(i));
    applyStimulus(8'h00);
    checkOutput("max_frame_ok", 32'(frame_ok), 32'd1);
    repeat (15) step();
    checkOutput("max_last_data", 32'(pl_data), 32'h10);
    checkOutput("max_last", 32'(pl_last), 32'd1);
    step();
    checkOutput("max_valid_end", 32'(pl_valid), 32'd0);
    checkOutput("max_hs_count", 32'(hs_cnt - hs0), 32'd16);
    checkOutput("max_hs_b7", 32'(hs_data[7]), 32'h08);

    // Timeout after 1024 silent ticks
    $display("[TB] inter-byte timeout");
    applyStimulus(8'hA5); applyStimulus(8'h04); applyStimulus(8'h01);
    tick_8x = 1'b1;
    repeat (1023) step();
    checkOutput("tmo_early", 32'(frame_err), 32'd0);
    step();
    tick_8x = 1'b0;
    checkOutput("tmo_err", 32'(frame_err), 32'd1);
    checkOutput("tmo_code", 32'(err_code), 32'd3);
    step();

    // rx_done on the terminal tick wins; CHK = 04^01^02^03^04 = 00
    $display("[TB] byte on terminal tick");
    err0 = err_cnt;
    applyStimulus(8'hA5); applyStimulus(8'h04); applyStimulus(8'h01);
    tick_8x = 1'b1;
    repeat (1023) step();
    applyStimulus(8'h02);
    tick_8x = 1'b0;
    checkOutput("race_no_err", 32'(frame_err), 32'd0);
    applyStimulus(8'h03); applyStimulus(8'h04); applyStimulus(8'h00);
    checkOutput("race_frame_ok", 32'(frame_ok), 32'd1);
    checkOutput("race_err_cnt", 32'(err_cnt - err0), 32'd0);
    repeat (4) step();
    checkOutput("race_valid_end", 32'(pl_valid), 32'd0);

    // enable low mid-frame aborts silently; leftover bytes are ignored
    $display("[TB] enable abort");
    ok0 = ok_cnt;
    err0 = err_cnt;
    applyStimulus(8'hA5); applyStimulus(8'h02); applyStimulus(8'h01);
    enable = 1'b0;
    step();
    checkOutput("ena_rx_en", 32'(rx_en), 32'd0);
    enable = 1'b1;
    applyStimulus(8'h02); applyStimulus(8'h03);
    step();
    checkOutput("ena_no_err", 32'(err_cnt - err0), 32'd0);
    checkOutput("ena_no_ok", 32'(ok_cnt - ok0), 32'd0);
    applyStimulus(8'hA5); applyStimulus(8'h01);
    applyStimulus(8'h5A); applyStimulus(8'h5B);
    checkOutput("ena_frame_ok", 32'(frame_ok), 32'd1);
    checkOutput("ena_last", 32'(pl_last), 32'd1);
    step();

    // Stalled drain: CHK = 02^AA^55 = FD, pl_ready 0,1,0,1
    $display("[TB] stalled drain");
    pl_ready = 1'b0;
    hs0 = hs_cnt;
    applyStimulus(8'hA5); applyStimulus(8'h02);
    applyStimulus(8'hAA); applyStimulus(8'h55); applyStimulus(8'hFD);
    checkOutput("stall_valid", 32'(pl_valid), 32'd1);
    checkOutput("stall_data0", 32'(pl_data), 32'hAA);
    step();
    checkOutput("stall_hold0", 32'(pl_data), 32'hAA);
    checkOutput("stall_last0", 32'(pl_last), 32'd0);
    pl_ready = 1'b1;
    step();
    checkOutput("stall_data1", 32'(pl_data), 32'h55);
    pl_ready = 1'b0;
    step();
    checkOutput("stall_hold1", 32'(pl_data), 32'h55);
    checkOutput("stall_last1", 32'(pl_last), 32'd1);
    pl_ready = 1'b1;
    step();
    checkOutput("stall_valid_end", 32'(pl_valid), 32'd0);
    checkOutput("stall_hs_count", 32'(hs_cnt - hs0), 32'd2);

    // Reset in the middle of payload collection
    $display("[TB] reset mid-payload and mid-drain");
    ok0 = ok_cnt;
    err0 = err_cnt;
    applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h01);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstp_valid", 32'(pl_valid), 32'd0);
    checkOutput("rstp_code", 32'(err_code), 32'd0);
    applyStimulus(8'h02); applyStimulus(8'h03); applyStimulus(8'h00);
    step();
    checkOutput("rstp_no_ok", 32'(ok_cnt - ok0), 32'd0);
    checkOutput("rstp_no_err", 32'(err_cnt - err0), 32'd0);

    // Reset during drain: CHK = 01^77 = 76, sink stalled
    pl_ready = 1'b0;
    applyStimulus(8'hA5); applyStimulus(8'h01);
    applyStimulus(8'h77); applyStimulus(8'h76);
    checkOutput("rstd_valid_pre", 32'(pl_valid), 32'd1);
    ok0 = ok_cnt + 1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstd_valid", 32'(pl_valid), 32'd0);
    checkOutput("rstd_data", 32'(pl_data), 32'd0);
    checkOutput("rstd_last", 32'(pl_last), 32'd0);
    checkOutput("rstd_ok", 32'(frame_ok), 32'd0);
    checkOutput("rstd_rx_en", 32'(rx_en), 32'd1);
    repeat (3) step();
    checkOutput("rstd_ok_cnt", 32'(ok_cnt), 32'(ok0));
    checkOutput("rstd_err_cnt", 32'(err_cnt - err0), 32'd0);

    checkOutput("no_ok_err_overlap", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
